// File: rtl/bufferpool_load_ctrl_if.sv
// Stream-in and pool-write-port bundle for the buffer pool load sequencer.
// The master side drives commands and beats; the slave side is the sequencer.
interface bufferpool_load_ctrl_if #(
    parameter int X_MAC    = 4,
    parameter int X_MESH   = 16,
    parameter int ADDR_LEN = 13,
    parameter int DATA_LEN = 32
);
    localparam int BUFFER_NUM = X_MAC * X_MESH;
    localparam int BEAT_WIDTH = X_MAC * DATA_LEN;

    logic                           start;
    logic [ADDR_LEN-1:0]            base_addr;
    logic [ADDR_LEN-1:0]            num_rows;
    logic                           busy;
    logic                           done;
    logic [BEAT_WIDTH-1:0]          s_data;
    logic                           s_valid;
    logic                           s_ready;
    logic [BUFFER_NUM*DATA_LEN-1:0] pool_dina;
    logic [BUFFER_NUM*ADDR_LEN-1:0] pool_addra;
    logic [BUFFER_NUM-1:0]          pool_wea;

    modport master (
        output start, base_addr, num_rows, s_data, s_valid,
        input  busy, done, s_ready, pool_dina, pool_addra, pool_wea
    );

    modport slave (
        input  start, base_addr, num_rows, s_data, s_valid,
        output busy, done, s_ready, pool_dina, pool_addra, pool_wea
    );
endinterface

// File: rtl/bufferpool_load_ctrl.sv
// Load sequencer: scatters X_MAC-word beats round-robin over X_MESH port groups
// of the BRAM pool, one registered write per accepted beat, and flags tile completion.
module bufferpool_load_ctrl #(
    parameter int X_MAC    = 4,
    parameter int X_MESH   = 16,
    parameter int ADDR_LEN = 13,
    parameter int DATA_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bufferpool_load_ctrl_if.slave bus
);
    localparam int BUFFER_NUM = X_MAC * X_MESH;
    localparam int PORT_W     = $clog2(X_MESH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                     state_q, state_d;
    logic [PORT_W-1:0]              port_cnt_q, port_cnt_d;
    logic [ADDR_LEN-1:0]            row_cnt_q, row_cnt_d;
    logic [ADDR_LEN-1:0]            base_q, base_d;
    logic [ADDR_LEN-1:0]            rows_q, rows_d;
    logic [BUFFER_NUM-1:0]          wea_q, wea_d;
    logic [BUFFER_NUM*ADDR_LEN-1:0] addra_q, addra_d;
    logic [BUFFER_NUM*DATA_LEN-1:0] dina_q, dina_d;

    logic                accept;
    logic                last_port;
    logic                last_row;
    logic [ADDR_LEN-1:0] wr_addr;

    assign accept    = bus.s_valid && (state_q == ST_LOAD);
    assign last_port = (port_cnt_q == PORT_W'(X_MESH - 1));
    assign last_row  = (row_cnt_q == rows_q - ADDR_LEN'(1));
    assign wr_addr   = base_q + row_cnt_q;

    always_comb begin
        state_d    = state_q;
        port_cnt_d = port_cnt_q;
        row_cnt_d  = row_cnt_q;
        base_d     = base_q;
        rows_d     = rows_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    base_d     = bus.base_addr;
                    rows_d     = bus.num_rows;
                    port_cnt_d = '0;
                    row_cnt_d  = '0;
                    state_d    = (bus.num_rows != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    port_cnt_d = port_cnt_q + PORT_W'(1);
                    if (last_port) begin
                        row_cnt_d = row_cnt_q + ADDR_LEN'(1);
                        if (last_row) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Data and address are broadcast to every bank; only the active group's enables fire.
    always_comb begin
        wea_d   = '0;
        addra_d = addra_q;
        dina_d  = dina_q;
        if (accept) begin
            addra_d = {BUFFER_NUM{wr_addr}};
            dina_d  = {X_MESH{bus.s_data}};
            for (int g = 0; g < X_MESH; g++) begin
                if (port_cnt_q == PORT_W'(g)) begin
                    wea_d[g*X_MAC +: X_MAC] = '1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            port_cnt_q <= '0;
            row_cnt_q  <= '0;
            base_q     <= '0;
            rows_q     <= '0;
            wea_q      <= '0;
            addra_q    <= '0;
            dina_q     <= '0;
        end else begin
            state_q    <= state_d;
            port_cnt_q <= port_cnt_d;
            row_cnt_q  <= row_cnt_d;
            base_q     <= base_d;
            rows_q     <= rows_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
        end
    end

    assign bus.s_ready    = (state_q == ST_LOAD);
    assign bus.busy       = (state_q == ST_LOAD);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.pool_wea   = wea_q;
    assign bus.pool_addra = addra_q;
    assign bus.pool_dina  = dina_q;
endmodule

// File: tb/tb_bufferpool_load_ctrl.sv
// Self-checking bench for bufferpool_load_ctrl: table of load scenarios plus
// hand-written reset sequence, with a scoreboard checking every pool write.
module tb_bufferpool_load_ctrl;
    localparam int X_MAC      = 4;
    localparam int X_MESH     = 16;
    localparam int ADDR_LEN   = 13;
    localparam int DATA_LEN   = 32;
    localparam int BUFFER_NUM = X_MAC * X_MESH;
    localparam int BEAT_WIDTH = X_MAC * DATA_LEN;

    typedef struct {
        logic [BUFFER_NUM-1:0] wea;
        logic [ADDR_LEN-1:0]   addr;
        logic [BEAT_WIDTH-1:0] data;
        int                    port;
    } exp_t;

    typedef struct {
        logic [ADDR_LEN-1:0] base;
        logic [ADDR_LEN-1:0] rows;
        bit                  gaps;
        bit                  pulse_mid;
        bit                  pulse_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    int checks      = 0;
    int failures    = 0;
    int wea_cycles  = 0;
    int done_count  = 0;
    int mon_beat    = 0;
    logic [ADDR_LEN-1:0] mon_base = '0;
    exp_t exp_q[$];
    vec_t vecs[5];

    bufferpool_load_ctrl_if #(
        .X_MAC(X_MAC), .X_MESH(X_MESH), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)
    ) bus ();

    bufferpool_load_ctrl #(
        .X_MAC(X_MAC), .X_MESH(X_MESH), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: push an expected write when a beat is handed over, pop when wea appears.
    exp_t mon_e;
    exp_t mon_n;
    int   mon_other;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.pool_wea != '0) begin
                wea_cycles++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_wea", 64'(bus.pool_wea), 64'(0));
                end else begin
                    mon_e     = exp_q.pop_front();
                    mon_other = (mon_e.port + 1) % X_MESH;
                    checkOutput("wea", 64'(bus.pool_wea), 64'(mon_e.wea));
                    checkOutput("addr_active_bank",
                                64'(bus.pool_addra[mon_e.port*X_MAC*ADDR_LEN +: ADDR_LEN]), 64'(mon_e.addr));
                    checkOutput("addr_bank0", 64'(bus.pool_addra[0 +: ADDR_LEN]), 64'(mon_e.addr));
                    checkOutput("addr_last_bank",
                                64'(bus.pool_addra[(BUFFER_NUM-1)*ADDR_LEN +: ADDR_LEN]), 64'(mon_e.addr));
                    for (int i = 0; i < X_MAC; i++) begin
                        checkOutput("data_word",
                                    64'(bus.pool_dina[(mon_e.port*X_MAC+i)*DATA_LEN +: DATA_LEN]),
                                    64'(mon_e.data[i*DATA_LEN +: DATA_LEN]));
                        checkOutput("data_replica",
                                    64'(bus.pool_dina[(mon_other*X_MAC+i)*DATA_LEN +: DATA_LEN]),
                                    64'(mon_e.data[i*DATA_LEN +: DATA_LEN]));
                    end
                end
            end else if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("missing_wea", 64'(bus.pool_wea), 64'(mon_e.wea));
            end
            if (bus.done) done_count++;
            if (bus.s_valid && bus.s_ready) begin
                mon_n.port = mon_beat % X_MESH;
                mon_n.wea  = {{(BUFFER_NUM-X_MAC){1'b0}}, {X_MAC{1'b1}}} << (X_MAC * mon_n.port);
                mon_n.addr = mon_base + ADDR_LEN'(mon_beat / X_MESH);
                mon_n.data = bus.s_data;
                exp_q.push_back(mon_n);
                mon_beat++;
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        int total;
        int sent;
        int guard;
        int done_before;
        int wea_before;
        bit acc;
        bit toggle;
        bit pulsed;
        total       = int'(v.rows) * X_MESH;
        sent        = 0;
        guard       = 0;
        toggle      = 1'b1;
        pulsed      = 1'b0;
        done_before = done_count;
        wea_before  = wea_cycles;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = v.base;
        bus.num_rows  = v.rows;
        mon_base      = v.base;
        mon_beat      = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (v.rows == '0) begin
            checkOutput("empty_done", 64'(bus.done), 64'(1));
            checkOutput("empty_busy", 64'(bus.busy), 64'(0));
            checkOutput("empty_ready", 64'(bus.s_ready), 64'(0));
            @(posedge clk); #1;
            checkOutput("empty_done_clear", 64'(bus.done), 64'(0));
            checkOutput("empty_busy_after", 64'(bus.busy), 64'(0));
        end else begin
            checkOutput("busy_on_load", 64'(bus.busy), 64'(1));
            checkOutput("ready_on_load", 64'(bus.s_ready), 64'(1));
            checkOutput("no_done_on_load", 64'(bus.done), 64'(0));
            while (sent < total && guard < total * 4 + 20) begin
                bus.s_valid = v.gaps ? toggle : 1'b1;
                bus.s_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                if (v.pulse_mid && sent == 5 && !pulsed) begin
                    bus.start     = 1'b1;
                    bus.base_addr = 13'd500;
                    bus.num_rows  = 13'd5;
                    pulsed        = 1'b1;
                end
                acc    = bus.s_valid && bus.s_ready;
                toggle = ~toggle;
                @(posedge clk); #1;
                bus.start = 1'b0;
                if (acc) sent++;
                guard++;
            end
            bus.s_valid = 1'b0;
            checkOutput("beats_accepted", 64'(sent), 64'(total));
            checkOutput("done_after_last", 64'(bus.done), 64'(1));
            checkOutput("busy_after_last", 64'(bus.busy), 64'(0));
            checkOutput("ready_after_last", 64'(bus.s_ready), 64'(0));
            if (v.pulse_done) begin
                bus.start     = 1'b1;
                bus.base_addr = 13'd700;
                bus.num_rows  = 13'd1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            checkOutput("done_one_cycle", 64'(bus.done), 64'(0));
            checkOutput("busy_in_idle", 64'(bus.busy), 64'(0));
            checkOutput("ready_in_idle", 64'(bus.s_ready), 64'(0));
            @(posedge clk); #1;
            checkOutput("ready_stays_idle", 64'(bus.s_ready), 64'(0));
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("done_count", 64'(done_count - done_before), 64'(1));
        checkOutput("wea_cycles", 64'(wea_cycles - wea_before), 64'(total));
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   sent;
        int   guard;
        int   done_before;
        bit   acc;
        vec_t fresh;

        vecs[0] = '{base: 13'd0,    rows: 13'd2, gaps: 1'b0, pulse_mid: 1'b0, pulse_done: 1'b0};
        vecs[1] = '{base: 13'd0,    rows: 13'd2, gaps: 1'b1, pulse_mid: 1'b0, pulse_done: 1'b0};
        vecs[2] = '{base: 13'd8190, rows: 13'd3, gaps: 1'b0, pulse_mid: 1'b0, pulse_done: 1'b0};
        vecs[3] = '{base: 13'd0,    rows: 13'd0, gaps: 1'b0, pulse_mid: 1'b0, pulse_done: 1'b0};
        vecs[4] = '{base: 13'd5,    rows: 13'd1, gaps: 1'b0, pulse_mid: 1'b1, pulse_done: 1'b1};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_rows  = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        #3;
        checkOutput("reset_busy", 64'(bus.busy), 64'(0));
        checkOutput("reset_done", 64'(bus.done), 64'(0));
        checkOutput("reset_ready", 64'(bus.s_ready), 64'(0));
        checkOutput("reset_wea", 64'(bus.pool_wea), 64'(0));
        checkOutput("reset_addra_any", 64'(|bus.pool_addra), 64'(0));
        checkOutput("reset_dina_any", 64'(|bus.pool_dina), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            $display("[TB] scenario %0d base=%0d rows=%0d gaps=%0d", k, vecs[k].base, vecs[k].rows, vecs[k].gaps);
            applyStimulus(vecs[k]);
        end

        // Reset in the middle of a load, right after beat 10 has been written.
        $display("[TB] reset during load");
        done_before = done_count;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = 13'd0;
        bus.num_rows  = 13'd2;
        mon_base      = 13'd0;
        mon_beat      = 0;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.s_valid = 1'b1;
        sent        = 0;
        guard       = 0;
        while (sent < 11 && guard < 50) begin
            bus.s_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            acc        = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            guard++;
        end
        checkOutput("rst_beats_before", 64'(sent), 64'(11));
        checkOutput("rst_wea_live", 64'(bus.pool_wea), 64'hF << (X_MAC * 10));
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_wea", 64'(bus.pool_wea), 64'(0));
        checkOutput("rst_async_busy", 64'(bus.busy), 64'(0));
        checkOutput("rst_async_ready", 64'(bus.s_ready), 64'(0));
        checkOutput("rst_async_done", 64'(bus.done), 64'(0));
        bus.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_no_done", 64'(done_count - done_before), 64'(0));
        checkOutput("rst_idle_busy", 64'(bus.busy), 64'(0));

        fresh = '{base: 13'd0, rows: 13'd1, gaps: 1'b0, pulse_mid: 1'b0, pulse_done: 1'b0};
        applyStimulus(fresh);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bufferpool_load_ctrl.md
# bufferpool_load_ctrl

Load sequencer for the X_MAC×X_MESH BRAM buffer pool. It accepts a valid/ready stream of beats, each X_MAC words wide, and scatters the beats round-robin across the X_MESH port groups. It generates the pool's port-A write address and per-bank write enables, and reports completion of each tile load. It sits between the DMA/input stream and the buffer pool's write port; the pool's read port is not touched.

## Interface

- X_MAC, 4, banks per port group (words per beat)
- X_MESH, 16, port groups; power of two, ≥2
- ADDR_LEN, 13, bank address width
- DATA_LEN, 32, word width
- BUFFER_NUM, X_MAC*X_MESH, total banks (derived)
- BEAT_WIDTH, X_MAC*DATA_LEN, stream beat width (derived)

One clock; reset is asynchronous and active-low.

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  load command, sampled only in IDLE
- base_addr  in  ADDR_LEN  first row address, latched on start
- num_rows  in  ADDR_LEN  rows per bank, latched on start; 0 = empty load
- busy  out  1  high while in LOAD
- done  out  1  one-cycle completion pulse
- s_data  in  BEAT_WIDTH  beat; word i at bits [i*DATA_LEN +: DATA_LEN]
- s_valid  in  1  beat valid
- s_ready  out  1  beat accepted when s_valid & s_ready
- pool_dina  out  BUFFER_NUM*DATA_LEN  pool write data
- pool_addra  out  BUFFER_NUM*ADDR_LEN  pool write addresses
- pool_wea  out  BUFFER_NUM  pool write enables

## Operation

- FSM states: IDLE, LOAD, DONE.
  - IDLE: on start, latch base_addr/num_rows and clear counters. Go to LOAD if num_rows≠0, else DONE.
  - LOAD: accept beats. After the beat with port_cnt=X_MESH-1 and row_cnt=num_rows-1 is accepted, go to DONE.
  - DONE: one cycle, then IDLE. start is ignored in LOAD and DONE.
- s_ready = (state==LOAD), combinational from state only; it does not depend on s_valid.
- Counters:
  - port_cnt is $clog2(X_MESH) bits and row_cnt is ADDR_LEN bits.
  - On each accepted beat, port_cnt increments. When port_cnt wraps from X_MESH-1 to 0, row_cnt increments.
- Beat k of a load maps to port p = k mod X_MESH and row r = k div X_MESH.
- Write address = (base_addr + r) mod 2^ADDR_LEN. Address wrap-around is silent and legal.
- Word i of the beat goes to bank b = p*X_MAC + i:
  - data at pool_dina[b*DATA_LEN +: DATA_LEN]
  - address at pool_addra[b*ADDR_LEN +: ADDR_LEN]
- The beat data is replicated to all X_MESH port groups of pool_dina, and the address is replicated to all banks. Only pool_wea[p*X_MAC +: X_MAC] goes high; all other wea bits stay 0.
- pool_dina, pool_addra and pool_wea are registered.
  - pool_wea is 0 in every cycle that follows a cycle with no accepted beat.
  - pool_dina and pool_addra hold their last value when no beat is accepted.
- busy = (state==LOAD); done = (state==DONE).

## Timing

- Reset values: state=IDLE, busy=0, done=0, s_ready=0, pool_wea=0, pool_dina=0, pool_addra=0, all counters 0. Reset mid-load drops the in-flight load and clears wea immediately (asynchronously); no done is issued for that load.
- start in cycle t (IDLE) → state=LOAD and s_ready=1 in cycle t+1.
- Write latency: a beat accepted in cycle T appears on pool_wea/pool_addra/pool_dina in cycle T+1.
- Throughput is 1 beat/cycle; a load of N rows takes at least N*X_MESH cycles in LOAD.
- Last beat accepted in cycle T → in cycle T+1, done=1, busy=0, s_ready=0 and the last wea is asserted. State is IDLE in T+2, where a new start may be accepted.
- num_rows=0: start in cycle t → done=1 in cycle t+1, busy never asserts, no wea.
- s_valid gaps stall the counters; no beat is dropped or duplicated.

## Test plan

- Defaults, start with base_addr=0, num_rows=2, 32 back-to-back beats:
  - beat 0 → wea=0x000F, addr 0
  - beat 17 → wea=0x00F0, addr 1, bank 5 data = word 1 of beat 17
  - done in the cycle after beat 31 is accepted, and exactly 32 wea cycles in total
- Same load with s_valid toggling 1,0,1,0 → wea pulses only in the cycle after each accepted beat; mapping is identical to the back-to-back case; done follows the 32nd accepted beat.
- base_addr=8190, num_rows=3, 48 beats → beats 0–15 write addr 8190, beats 16–31 write addr 8191, beats 32–47 write addr 0.
- num_rows=0 → done=1 exactly one cycle after start, pool_wea stays 0, busy stays 0.
- start pulsed during LOAD, and again in the DONE cycle → both ignored; latched base/num_rows unchanged; only one done per accepted start.
- rst_n low after beat 10 of a 2-row load → pool_wea=0 and busy=0 asynchronously, no done. A fresh start (base_addr=0, num_rows=1) then writes beat 0 to wea=0x000F, addr 0.
